// File: rtl/ir_pkg.sv
// Shared types, frame geometry and default timing for the RC5 infrared transmitter.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ir_state_e;

  localparam int RC5_FRAME_BITS = 14;
  localparam int RC5_HALF_BITS  = 28;

  // 50 MHz system clock, 36 kHz carrier, 889 us half-bit, 113.8 ms repeat.
  localparam int DEF_CLK_DIV       = 1389;
  localparam int DEF_CARRIER_HIGH  = 463;
  localparam int DEF_HALF_BIT      = 32;
  localparam int DEF_FRAME_PERIODS = 4096;

  // Frame word, MSB sent first: S1, S2, T, A4..A0, C5..C0.
  function automatic logic [RC5_FRAME_BITS-1:0] rc5_frame(input logic       s2,
                                                          input logic       t,
                                                          input logic [4:0] addr,
                                                          input logic [5:0] cmd);
    return {1'b1, s2, t, addr, cmd};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier period counter: high-phase level for LED modulation and a wrap tick
// that paces the half-bit and frame counters.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CARRIER_HIGH = DEF_CARRIER_HIGH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic carrier,
  output logic period_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] carrier_cnt_q;
  logic [CW-1:0] carrier_cnt_d;

  // Free-running 0..CLK_DIV-1 counter, held at zero while cleared.
  always_comb begin
    carrier_cnt_d = carrier_cnt_q;
    if (clear || (carrier_cnt_q == LAST)) begin
      carrier_cnt_d = '0;
    end else begin
      carrier_cnt_d = carrier_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carrier_cnt_q <= '0;
    end else begin
      carrier_cnt_q <= carrier_cnt_d;
    end
  end

  assign carrier     = (int'(carrier_cnt_q) < CARRIER_HIGH);
  assign period_tick = (carrier_cnt_q == LAST) && !clear;

endmodule

// File: rtl/ir_rc5_tx.sv
// RC5 infrared transmitter: Manchester-coded 14-bit frame on a modulated
// carrier, repeated while the key is held, toggle bit flipped per keypress.
// Build option: define RC5X_EN to send S2 = ~cmd[6] (128 commands);
// otherwise S2 is fixed at 1 and cmd[6] is ignored.
module ir_rc5_tx
  import ir_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int CARRIER_HIGH  = DEF_CARRIER_HIGH,
  parameter int HALF_BIT      = DEF_HALF_BIT,
  parameter int FRAME_PERIODS = DEF_FRAME_PERIODS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [4:0] addr,
  input  logic [6:0] cmd,
  output logic       ir_out,
  output logic       busy,
  output logic       frame_done,
  output logic       toggle
);

  localparam int            HW         = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int            FW         = (FRAME_PERIODS > 1) ? $clog2(FRAME_PERIODS) : 1;
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_BIT - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_PERIODS - 1);
  localparam logic [4:0]    HB_LAST    = 5'(RC5_HALF_BITS - 1);

  ir_state_e     state_q, state_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic [4:0]    hb_idx_q, hb_idx_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [4:0]    addr_q, addr_d;
  logic [6:0]    cmd_q, cmd_d;
  logic          toggle_q, toggle_d;
  logic          ir_out_q, ir_out_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic                      carrier;
  logic                      period_tick;
  logic [6:0]                cmd_eff;
  logic                      s2;
  logic [RC5_FRAME_BITS-1:0] frame_word;
  logic [3:0]                bit_sel;
  logic                      cur_bit;
  logic                      mark;
  logic                      same_key;

`ifdef RC5X_EN
  assign cmd_eff = cmd;
  assign s2      = ~cmd_q[6];
`else
  // cmd[6] carries no meaning in plain RC5; it is kept out of the latch
  // so that flipping it never restarts or re-toggles a held key.
  logic cmd6_unused;
  assign cmd6_unused = cmd[6];
  assign cmd_eff     = {1'b0, cmd[5:0]};
  assign s2          = 1'b1;
`endif

  ir_carrier_gen #(
    .CLK_DIV      (CLK_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk         (clk),
    .reset       (reset),
    .clear       (state_q == IDLE),
    .carrier     (carrier),
    .period_tick (period_tick)
  );

  // Current half-bit level: even halves carry the inverted bit, odd halves the bit.
  assign frame_word = rc5_frame(s2, toggle_q, addr_q, cmd_q[5:0]);
  assign bit_sel    = 4'd13 - hb_idx_q[4:1];
  assign cur_bit    = frame_word[bit_sel];
  assign mark       = hb_idx_q[0] ? cur_bit : ~cur_bit;
  assign same_key   = send && (addr == addr_q) && (cmd_eff == cmd_q);

  // Next-state logic: frame sequencing, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    half_cnt_d   = half_cnt_q;
    hb_idx_d     = hb_idx_q;
    frame_cnt_d  = frame_cnt_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    toggle_d     = toggle_q;
    frame_done_d = 1'b0;
    ir_out_d     = (state_q == SEND) && mark && carrier;
    busy_d       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (send) begin
          state_d     = SEND;
          addr_d      = addr;
          cmd_d       = cmd_eff;
          half_cnt_d  = '0;
          hb_idx_d    = '0;
          frame_cnt_d = '0;
        end
      end
      SEND: begin
        if (period_tick) begin
          frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
          if (half_cnt_q == HALF_LAST) begin
            half_cnt_d = '0;
            if (hb_idx_q == HB_LAST) begin
              hb_idx_d     = '0;
              frame_done_d = 1'b1;
              state_d      = GAP;
            end else begin
              hb_idx_d = hb_idx_q + 1'b1;
            end
          end else begin
            half_cnt_d = half_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (period_tick) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            half_cnt_d  = '0;
            hb_idx_d    = '0;
            if (same_key) begin
              state_d = SEND;
            end else begin
              state_d  = IDLE;
              toggle_d = ~toggle_q;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, latched key and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      half_cnt_q   <= '0;
      hb_idx_q     <= '0;
      frame_cnt_q  <= '0;
      addr_q       <= '0;
      cmd_q        <= '0;
      toggle_q     <= 1'b0;
      ir_out_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_cnt_q   <= half_cnt_d;
      hb_idx_q     <= hb_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      toggle_q     <= toggle_d;
      ir_out_q     <= ir_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ir_out     = ir_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign toggle     = toggle_q;

endmodule

// File: tb/tb_ir_rc5_tx.sv
// Self-checking bench for ir_rc5_tx with a time-based reference model.
module tb_ir_rc5_tx;

  localparam int CD  = 4;
  localparam int CH  = 1;
  localparam int HB  = 32;
  localparam int FP  = 128;
  localparam int HBC = HB * CD;                   // clk per half-bit
  localparam int FL  = 28 * HBC;                  // clk per frame
  localparam int P   = ((28 * HB) / FP + 1) * FP * CD; // clk frame start to start

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [4:0] addr;
  logic [6:0] cmd;
  logic       ir_out;
  logic       busy;
  logic       frame_done;
  logic       toggle;

  always #5 clk = ~clk;

  ir_rc5_tx #(
    .CLK_DIV       (CD),
    .CARRIER_HIGH  (CH),
    .HALF_BIT      (HB),
    .FRAME_PERIODS (FP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .addr       (addr),
    .cmd        (cmd),
    .ir_out     (ir_out),
    .busy       (busy),
    .frame_done (frame_done),
    .toggle     (toggle)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          m_active = 0;
  int          m_s = 0;
  logic [4:0]  m_addr;
  logic [6:0]  m_cmd;
  bit          m_tog = 0;
  logic [13:0] m_word;
  int          hcnt[28];
  int          acc_cyc = 0;
  int          fm_cyc = -1;
  int          fd_cyc = -1;
  int          bf_cyc = -1;
  int          n_fd = 0;

  function automatic logic [6:0] eff_cmd(input logic [6:0] c);
`ifdef RC5X_EN
    return c;
`else
    return {1'b0, c[5:0]};
`endif
  endfunction

  function automatic logic [13:0] exp_word(input logic t, input logic [4:0] a, input logic [6:0] c);
    logic s2;
`ifdef RC5X_EN
    s2 = ~c[6];
`else
    s2 = 1'b1;
`endif
    return {1'b1, s2, t, a, c[5:0]};
  endfunction

  // LED level at position u (clk since frame start) from the Manchester rule.
  function automatic bit exp_mark(input logic [13:0] w, input int u);
    int h;
    bit b;
    h = u / HBC;
    b = w[13 - h / 2];
    return (h % 2 == 0) ? !b : b;
  endfunction

  task automatic start_frame(input bit from_idle);
    m_active = 1;
    m_s      = cyc;
    m_addr   = addr;
    m_cmd    = eff_cmd(cmd);
    m_word   = exp_word(m_tog, addr, cmd);
    exp_q.push_back(m_word);
    for (int i = 0; i < 28; i++) hcnt[i] = 0;
    if (from_idle) begin
      acc_cyc = cyc;
      fm_cyc  = -1;
      fd_cyc  = -1;
      bf_cyc  = -1;
    end
  endtask

  // One clock: advance the model on the edge, compare all outputs half a cycle later.
  task automatic step();
    bit          was_active;
    int          u;
    logic        ir_e;
    logic        fd_e;
    logic [13:0] got_w;
    int          bad;
    @(posedge clk);
    cyc++;
    was_active = m_active;
    if (!reset) begin
      if (!m_active) begin
        if (send) start_frame(1);
      end else if (cyc == m_s + P) begin
        if (send && addr == m_addr && eff_cmd(cmd) == m_cmd) start_frame(0);
        else begin
          m_active = 0;
          m_tog    = ~m_tog;
        end
      end
    end
    @(negedge clk);
    u    = cyc - 1 - m_s;
    ir_e = m_active && u >= 0 && u < FL && exp_mark(m_word, u) && (u % CD < CH);
    fd_e = m_active && cyc == m_s + FL;
    check("outs{ir,busy,done,tog}", {ir_out, busy, frame_done, toggle},
          {ir_e, logic'(was_active), fd_e, logic'(m_tog)});
    if (frame_done === 1'b1) n_fd++;
    if (fm_cyc < 0 && ir_out === 1'b1) fm_cyc = cyc;
    if (fd_cyc < 0 && frame_done === 1'b1) fd_cyc = cyc;
    if (bf_cyc < 0 && busy === 1'b0 && cyc > acc_cyc + 1) bf_cyc = cyc;
    if (m_active && u >= 0 && u < FL && ir_out === 1'b1) hcnt[u / HBC]++;
    if (fd_e) begin
      bad = 0;
      for (int i = 0; i < 14; i++) begin
        got_w[13 - i] = (hcnt[2 * i + 1] > 0);
        if ((hcnt[2 * i] > 0) == (hcnt[2 * i + 1] > 0)) bad++;
      end
      if (exp_q.size() == 0) check("frame_queue", 0, 1);
      else check("frame_decode", got_w, exp_q.pop_front());
      check("manchester_pairs_bad", bad, 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && m_active; i++) step();
    if (m_active) check("idle_timeout", 0, 1);
  endtask

  task automatic press(input logic [4:0] a, input logic [6:0] c);
    addr = a;
    cmd  = c;
    send = 1'b1;
    step();
    send = 1'b0;
    wait_idle(2 * P + 10);
    run(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int fd0;
    int i;
    reset = 1'b1;
    send  = 1'b0;
    addr  = '0;
    cmd   = '0;
    run(3);
    reset = 1'b0;
    run(2);

    // Test 1: single short press, addr 0 cmd 2, timing landmarks.
    press(5'd0, 7'd2);
    check("t1_first_mark", fm_cyc - acc_cyc, 1 + HBC);
    check("t1_frame_done", fd_cyc - acc_cyc, FL);
    check("t1_busy_fall", bf_cyc - acc_cyc, P + 1);
    check("t1_toggle", toggle, 1);

    // Test 2: key held for three frames, same toggle throughout.
    fd0  = n_fd;
    addr = 5'($urandom_range(0, 31));
    cmd  = 7'd2;
    send = 1'b1;
    step();
    run(2 * P + FL + 5);
    send = 1'b0;
    wait_idle(P + 10);
    check("t2_done_count", n_fd - fd0, 3);

    // Test 3: press, release, press with cmd 8.
    press(5'($urandom_range(0, 31)), 7'd8);
    press(5'($urandom_range(0, 31)), 7'd8);

    // Test 4: reset during a mark, then a fresh frame with T=0.
    addr = 5'($urandom_range(0, 31));
    cmd  = 7'($urandom_range(0, 63));
    send = 1'b1;
    step();
    send = 1'b0;
    for (i = 0; i < 1500 && !(cyc - m_s >= 1000 && ir_out === 1'b1); i++) step();
    if (!(ir_out === 1'b1)) check("t4_wait_mark", 0, 1);
    #1 reset = 1'b1;
    #1;
    check("t4_rst_ir_out", ir_out, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_toggle", toggle, 0);
    check("t4_rst_frame_done", frame_done, 0);
    m_active = 0;
    m_tog    = 0;
    exp_q.delete();
    run(3);
    reset = 1'b0;
    run(2);
    press(5'($urandom_range(0, 31)), 7'($urandom_range(0, 63)));

    // Test 5: held key, cmd changes 2 -> 4 during the gap.
    addr = 5'($urandom_range(0, 31));
    cmd  = 7'd2;
    send = 1'b1;
    step();
    s0 = m_s;
    run(FL + 50);
    cmd = 7'd4;
    for (i = 0; i < P + 10 && m_s == s0; i++) step();
    if (m_s == s0) check("t5_restart_timeout", 0, 1);
    run(FL + 10);
    send = 1'b0;
    wait_idle(P + 10);

    // Test 6: cmd 0x45 (S2 depends on build), then cmd[6] flip on a held key.
    press(5'($urandom_range(0, 31)), 7'h45);
    addr = 5'($urandom_range(0, 31));
    cmd  = 7'h05;
    send = 1'b1;
    step();
    run(FL + 20);
    cmd = 7'h45;
    run(P);
    send = 1'b0;
    wait_idle(2 * P + 10);

    // Random presses of random length.
    for (int r = 0; r < 2; r++) begin
      addr = 5'($urandom_range(0, 31));
      cmd  = 7'($urandom_range(0, 127));
      send = 1'b1;
      run($urandom_range(1, FL));
      send = 1'b0;
      wait_idle(2 * P + 10);
      run($urandom_range(1, 20));
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
